// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: feeds a registered one-bit full adder LSB-first,
// closes the carry loop combinationally and assembles the parallel sum.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_in1,
  output logic             fa_in2,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] acc_shift;

  // Sum bits arrive one cycle behind their inputs, so they enter at the MSB.
  assign acc_shift = WIDTH'({fa_sum, acc_q} >> 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          cin_d   = cin_init;
          cnt_d   = '0;
          state_d = FEED;
        end else begin
          state_d = IDLE;
        end
      end
      FEED: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q != '0) acc_d = acc_shift;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_d    = acc_shift;
        result_d = acc_shift;
        cout_d   = fa_cout;
        state_d  = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // fa_cout -> fa_cin is the only combinational input-to-output path.
  assign fa_in1    = (state_q == FEED) & opa_q[0];
  assign fa_in2    = (state_q == FEED) & opb_q[0];
  assign fa_cin    = (state_q == FEED) & ((cnt_q == '0) ? cin_q : fa_cout);
  assign busy      = (state_q == FEED) | (state_q == DRAIN);
  assign done      = (state_q == FIN);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add sequencer that sits directly upstream of the registered one-bit full adder and drives it. It accepts two WIDTH-bit operands and a carry-in, then presents the operands to the adder LSB-first, one bit per cycle. The adder's carry-out is fed back as the next bit's carry-in. The returned sum bits and final carry are assembled into a parallel result. The adder's one-cycle input-register latency is absorbed here.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock, shared with the full adder.
- reset  input  1  synchronous, active-high; the top level drives the adder's active-low reset from its inverse.
- start  input  1  request to begin an addition; honoured only when busy=0.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- cin_init  input  1  carry into bit 0, sampled on the accepting edge.
- busy  output  1  high while an addition is in flight.
- done  output  1  one-cycle pulse: result and carry_out just updated.
- result  output  WIDTH  sum of the last completed addition.
- carry_out  output  1  carry out of bit WIDTH-1 of the last completed addition.
- fa_in1  output  1  to adder in1.
- fa_in2  output  1  to adder in2.
- fa_cin  output  1  to adder cin.
- fa_sum  input  1  from adder sum; combinational from the adder's registered inputs.
- fa_cout  input  1  from adder cout; same timing as fa_sum.

## Operation
- FSM states: IDLE, FEED, DRAIN, FIN.
- IDLE: busy=0, fa_* outputs=0.
  - start=1 captures a and b into shift registers opA and opB, captures cin_init, clears bit counter cnt, and goes to FEED.
- FEED: runs for exactly WIDTH cycles, cnt = 0..WIDTH-1.
  - fa_in1=opA[0], fa_in2=opB[0].
  - fa_cin = cin_init when cnt=0, otherwise fa_cout (combinational feedback).
  - Each edge shifts opA and opB right by one and increments cnt.
  - When cnt>=1, each edge shifts fa_sum into the MSB of the accumulator acc (shift right). acc holds the sum bit from the previous cycle's inputs.
  - Leaves to DRAIN on the edge where cnt=WIDTH-1.
- DRAIN: one cycle.
  - fa_* outputs=0.
  - Captures the final fa_sum into acc. After this shift, acc[WIDTH-1:0] holds sum bits 0..WIDTH-1 in order.
  - Captures fa_cout into carry_out.
  - Copies the completed acc into result.
  - Goes to FIN.
- FIN: one cycle.
  - done=1, busy=0.
  - start is honoured here exactly as in IDLE (back-to-back operation); otherwise the FSM goes to IDLE.
- Arithmetic: {carry_out,result} = a + b + cin_init, modulo 2^(WIDTH+1). Operands are unsigned.
- result and carry_out change only on the DRAIN→FIN edge and hold until the next completion. Intermediate sums are never visible on result.
- start while busy=1 is ignored; no queueing, no error flag.
- a, b and cin_init may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, result=0, carry_out=0, fa_in1=0, fa_in2=0, fa_cin=0, state=IDLE, cnt=0.
- The accepting edge is cycle 0. Bit i is driven on fa_* during cycle 1+i.
- Sum bit i appears on fa_sum during cycle 2+i.
- The carry from bit i is on fa_cout during cycle 2+i and is driven to fa_cin in that same cycle.
- busy=1 during cycles 1..WIDTH+1.
- done=1 in cycle WIDTH+2. Start-to-done latency is WIDTH+2 cycles.
- Throughput: a start in the FIN cycle yields one addition every WIDTH+2 cycles.
- Reset asserted in any state:
  - Next edge forces all reset values and abandons any in-flight addition.
  - result and carry_out are cleared.
  - No done pulse is generated for the abandoned operation.
- Reset and start in the same cycle: reset wins; start is dropped.
- The only combinational path is fa_cout→fa_cin. No other output depends combinationally on an input.

## Test plan
- WIDTH=8, a=8'h03, b=8'h05, cin_init=0, start pulsed at cycle 0 → done in cycle 10 with result=8'h08, carry_out=0; busy=1 in cycles 1..9.
- a=8'hFF, b=8'h01, cin_init=0 → result=8'h00, carry_out=1. Checks the full ripple carry chain across every bit.
- a=8'hFF, b=8'hFF, cin_init=1 → result=8'hFF, carry_out=1. Then a=8'h00, b=8'h00, cin_init=0 started in the FIN cycle → second done 10 cycles later with result=8'h00, carry_out=0.
- Start pulsed again in cycle 4 of an addition of 8'h10+8'h20 → ignored; result=8'h30 at cycle 10, and no second done.
- Reset asserted in cycle 5 of 8'hAA+8'h55 → next cycle busy=0 and result=0; no done ever appears for that operation. A new start then completes normally.
- Random a, b and cin_init, 1000 iterations, compared against a+b+cin → {carry_out,result} exact, and done latency always WIDTH+2.
